// File: rtl/shift_register_univ.sv
// Universal shift register: parallel load, left/right shift and rotate, with fill tracking
// that flags when serial_out carries a real (non-filler) data bit.
module shift_register_univ #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         load,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic                         serial_in,
  input  logic [WIDTH-1:0]             load_data,
  output logic [WIDTH-1:0]             par_out,
  output logic                         serial_out,
  output logic                         out_valid,
  output logic [$clog2(WIDTH+1)-1:0]   fill_count,
  output logic                         full
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FillMax = CW'(WIDTH);

  typedef enum logic [1:0] {
    ModeShl = 2'b00,
    ModeShr = 2'b01,
    ModeRol = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  logic [WIDTH-1:0] par_q, par_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             full_q, full_d;

  always_comb begin
    par_d   = par_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    full_d  = full_q;
    if (clear) begin
      par_d   = '0;
      sout_d  = 1'b0;
      valid_d = 1'b0;
      fill_d  = '0;
      full_d  = 1'b0;
    end else if (load) begin
      par_d   = load_data;
      valid_d = 1'b0;
      fill_d  = FillMax;
      full_d  = 1'b1;
    end else if (enable) begin
      // A real bit leaves only once the register was completely filled before this operation.
      valid_d = (fill_q == FillMax);
      unique case (mode_e'(mode))
        ModeShl: begin
          par_d  = {par_q[WIDTH-2:0], serial_in};
          sout_d = par_q[WIDTH-1];
        end
        ModeShr: begin
          par_d  = {serial_in, par_q[WIDTH-1:1]};
          sout_d = par_q[0];
        end
        ModeRol: begin
          par_d  = {par_q[WIDTH-2:0], par_q[WIDTH-1]};
          sout_d = par_q[WIDTH-1];
        end
        ModeRor: begin
          par_d  = {par_q[0], par_q[WIDTH-1:1]};
          sout_d = par_q[0];
        end
        default: ;
      endcase
      if (!mode[1] && (fill_q != FillMax)) begin
        fill_d = fill_q + CW'(1);
      end
      full_d = (fill_d == FillMax);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      fill_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      par_q   <= par_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
    end
  end

  assign par_out    = par_q;
  assign serial_out = sout_q;
  assign out_valid  = valid_q;
  assign fill_count = fill_q;
  assign full       = full_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed self-checking bench for shift_register_univ at WIDTH=8.
module tb_shift_register_univ;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             load = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic [WIDTH-1:0] par_out;
  logic             serial_out;
  logic             out_valid;
  logic [CW-1:0]    fill_count;
  logic             full;

  int n_checks = 0;
  int n_fail = 0;

  shift_register_univ #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .load       (load),
    .enable     (enable),
    .mode       (mode),
    .serial_in  (serial_in),
    .load_data  (load_data),
    .par_out    (par_out),
    .serial_out (serial_out),
    .out_valid  (out_valid),
    .fill_count (fill_count),
    .full       (full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] p, input logic so,
                           input logic ov, input int fc, input logic fl);
    check({tag, ".par"}, 32'(par_out), 32'(p));
    check({tag, ".sout"}, 32'(serial_out), 32'(so));
    check({tag, ".valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".fill"}, 32'(fill_count), 32'(fc));
    check({tag, ".full"}, 32'(full), 32'(fl));
  endtask

  // Advance one clock edge and settle inputs/outputs away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] bits2;
    logic [7:0] rot_exp;
    bits2 = 8'b1011_0010;
    rot_exp = 8'hA5;

    // Power-on reset
    step();
    check_all("por", 8'h00, 1'b0, 1'b0, 0, 1'b0);
    reset = 1'b1;

    // 1: async reset mid-cycle after loading FF
    load = 1'b1; load_data = 8'hFF;
    step();
    load = 1'b0;
    check_all("t1_load", 8'hFF, 1'b0, 1'b0, 8, 1'b1);
    #2 reset = 1'b0;
    #1 check_all("t1_async", 8'h00, 1'b0, 1'b0, 0, 1'b0);
    #2 reset = 1'b1;

    // 2: shift left 1,0,1,1,0,0,1,0 then 0
    mode = 2'b00; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serial_in = bits2[7-i];
      step();
      check("t2_fill", 32'(fill_count), 32'(i + 1));
      check("t2_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end
    check("t2_par8", 32'(par_out), 32'hB2);
    check("t2_valid8", 32'(out_valid), 32'd0);
    serial_in = 1'b0;
    step();
    check_all("t2_ninth", 8'h64, 1'b1, 1'b1, 8, 1'b1);
    enable = 1'b0;

    // 3: load A5, rotate left 8 times
    load = 1'b1; load_data = 8'hA5;
    step();
    load = 1'b0;
    check("t3_load_valid", 32'(out_valid), 32'd0);
    mode = 2'b10; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_sout", 32'(serial_out), 32'(rot_exp[7-i]));
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_fill", 32'(fill_count), 32'd8);
    end
    check("t3_par", 32'(par_out), 32'hA5);

    // Rotate right then shift right with the register still full
    enable = 1'b0;
    load = 1'b1; load_data = 8'h81;
    step();
    load = 1'b0; enable = 1'b1; mode = 2'b11;
    step();
    check_all("ror", 8'hC0, 1'b1, 1'b1, 8, 1'b1);
    mode = 2'b01; serial_in = 1'b0;
    step();
    check_all("shr_full", 8'h60, 1'b0, 1'b1, 8, 1'b1);

    // 4: clear then shift right three ones
    enable = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    check_all("t4_clear", 8'h00, 1'b0, 1'b0, 0, 1'b0);
    mode = 2'b01; serial_in = 1'b1; enable = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    check_all("t4", 8'hE0, 1'b0, 1'b0, 3, 1'b0);

    // 5: priority clear > load > enable
    load = 1'b1; load_data = 8'h5A;
    step();
    check("t5_pre", 32'(par_out), 32'h5A);
    clear = 1'b1; enable = 1'b1; mode = 2'b00; serial_in = 1'b1;
    step();
    clear = 1'b0;
    check_all("t5_clear", 8'h00, 1'b0, 1'b0, 0, 1'b0);
    load_data = 8'h3C;
    step();
    load = 1'b0; enable = 1'b0;
    check_all("t5_load", 8'h3C, 1'b0, 1'b0, 8, 1'b1);

    // 6: hold with enable low while mode/serial_in toggle
    clear = 1'b1;
    step();
    clear = 1'b0; enable = 1'b1; mode = 2'b00;
    serial_in = 1'b1; step();
    serial_in = 1'b1; step();
    serial_in = 1'b0; step();
    enable = 1'b0;
    check_all("t6_pre", 8'h06, 1'b0, 1'b0, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      mode = 2'(i);
      serial_in = ~serial_in;
      step();
      check_all("t6_hold", 8'h06, 1'b0, 1'b0, 3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
